// File: rtl/unsigned_mul_8x8_ha_array_sum_pkg.sv
// Shared widths and row type for the approximate 8x8 multiplier summation stage.
package unsigned_mul_8x8_ha_array_sum_pkg;

  localparam int unsigned ROW_B_W   = 7;
  localparam int unsigned ROW_T_W   = 9;
  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned ROW_SHIFT = 2;
  localparam int unsigned PROD_W    = 17;

  // r_k tops out at 1019; a pair sum r + (r << 2) tops out at 5095.
  localparam int unsigned ROW_VAL_W  = 10;
  localparam int unsigned PAIR_W     = 13;
  localparam int unsigned PAIR_SHIFT = 2 * ROW_SHIFT;

  typedef struct packed {
    logic [ROW_B_W-1:0] b;
    logic [ROW_T_W-1:0] t;
  } row_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_array_sum_ha_row_value.sv
// Combinational value of one half-adder row: sum bits at weight 2^i, carries at 2^(i+2).
module unsigned_mul_8x8_ha_array_sum_ha_row_value
  import unsigned_mul_8x8_ha_array_sum_pkg::*;
(
  input  row_t                 row,
  output logic [ROW_VAL_W-1:0] value
);

  assign value = ROW_VAL_W'(row.t) + (ROW_VAL_W'(row.b) << ROW_SHIFT);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_sum.sv
// Two-stage elastic summation of the four half-adder rows into a 17-bit product,
// with a saturating count of accepted row sets.
module unsigned_mul_8x8_ha_array_sum
  import unsigned_mul_8x8_ha_array_sum_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_B_W-1:0] ha_array_0_b,
  input  logic [ROW_T_W-1:0] ha_array_0_t,
  input  logic [ROW_B_W-1:0] ha_array_1_b,
  input  logic [ROW_T_W-1:0] ha_array_1_t,
  input  logic [ROW_B_W-1:0] ha_array_2_b,
  input  logic [ROW_T_W-1:0] ha_array_2_t,
  input  logic [ROW_B_W-1:0] ha_array_3_b,
  input  logic [ROW_T_W-1:0] ha_array_3_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  product,
  output logic [CNT_W-1:0]   txn_count
);

  row_t                 rows    [NUM_ROWS];
  logic [ROW_VAL_W-1:0] row_val [NUM_ROWS];

  assign rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
  assign rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
  assign rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
  assign rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};

  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row
    unsigned_mul_8x8_ha_array_sum_ha_row_value u_row (
      .row   (rows[k]),
      .value (row_val[k])
    );
  end

  logic              v1_q, v2_q;
  logic [PAIR_W-1:0] s01_q, s23_q, s01_d, s23_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              s1_load, s2_load, accept;

  // in_ready is combinational from out_ready: a full pipe frees a slot in the same cycle.
  always_comb begin
    s2_load = !v2_q || out_ready;
    s1_load = !v1_q || s2_load;
    accept  = in_valid && s1_load;
    s01_d   = PAIR_W'(row_val[0]) + (PAIR_W'(row_val[1]) << ROW_SHIFT);
    s23_d   = PAIR_W'(row_val[2]) + (PAIR_W'(row_val[3]) << ROW_SHIFT);
    prod_d  = PROD_W'(s01_q) + (PROD_W'(s23_q) << PAIR_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s01_q  <= '0;
      s23_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (s1_load) begin
        v1_q <= accept;
        if (accept) begin
          s01_q <= s01_d;
          s23_q <= s23_d;
        end
      end
      if (s2_load) begin
        v2_q <= v1_q;
        if (v1_q) begin
          prod_q <= prod_d;
        end
      end
      if (accept && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = v2_q;
  assign product   = prod_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_sum.sv
// Randomised and directed checks of the summation stage against an arithmetic product model.
module tb_unsigned_mul_8x8_ha_array_sum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [6:0]  rb [4];
  logic [8:0]  rt [4];
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [16:0] product, product2;
  logic [15:0] txn_count;
  logic [1:0]  txn_count2;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_array_sum dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (rb[0]),
    .ha_array_0_t (rt[0]),
    .ha_array_1_b (rb[1]),
    .ha_array_1_t (rt[1]),
    .ha_array_2_b (rb[2]),
    .ha_array_2_t (rt[2]),
    .ha_array_3_b (rb[3]),
    .ha_array_3_t (rt[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .txn_count    (txn_count)
  );

  unsigned_mul_8x8_ha_array_sum #(.CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready2),
    .ha_array_0_b (rb[0]),
    .ha_array_0_t (rt[0]),
    .ha_array_1_b (rb[1]),
    .ha_array_1_t (rt[1]),
    .ha_array_2_b (rb[2]),
    .ha_array_2_t (rt[2]),
    .ha_array_3_b (rb[3]),
    .ha_array_3_t (rt[3]),
    .out_valid    (out_valid2),
    .out_ready    (out_ready),
    .product      (product2),
    .txn_count    (txn_count2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned q[$];
  int unsigned n_acc = 0;
  int unsigned n_drained = 0;
  bit          hold_chk = 1'b0;
  logic [16:0] hold_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each row is sum bits plus carries weighted x4; rows are weighted 1,4,16,64.
  function automatic int unsigned model();
    int unsigned acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc += (int'(rt[k]) + 4 * int'(rb[k])) * (1 << (2 * k));
    end
    return acc;
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      rb[k] = '0;
      rt[k] = '0;
    end
  endtask

  task automatic rand_rows();
    for (int k = 0; k < 4; k++) begin
      rb[k] = 7'($urandom);
      rt[k] = 9'($urandom);
    end
  endtask

  // One clock: checks handshake and output against the model, then crosses the edge.
  task automatic step();
    bit acc, drn;
    #1;
    check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    check("in_ready_cnt2", 32'(in_ready2), 32'(in_ready));
    if (q.size() == 0) check("idle_out_valid", 32'(out_valid), 32'd0);
    if (hold_chk) check("hold_product", 32'(product), 32'(hold_val));
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (q.size() == 0) check("spurious_result", 32'(out_valid), 32'd0);
      else check("product", 32'(product), q.pop_front());
      n_drained++;
    end
    hold_chk = out_valid && !out_ready;
    hold_val = product;
    if (acc) begin
      q.push_back(model());
      n_acc++;
    end
    @(posedge clk);
    #1;
    check("txn_count", 32'(txn_count), (n_acc > 65535) ? 32'd65535 : n_acc);
    check("txn_count_cnt2", 32'(txn_count2), (n_acc > 3) ? 32'd3 : n_acc);
  endtask

  task automatic single(input string tag, input int unsigned exp);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(product), exp);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_txn_count", 32'(txn_count), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    q.delete();
    n_acc    = 0;
    hold_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_rows();
    do_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    clear_rows();
    single("zero", 0);
    check("zero_count", 32'(txn_count), 32'd1);
    clear_rows(); rt[0] = 9'h001;
    single("t0_lsb", 1);
    clear_rows(); rb[3] = 7'h40;
    single("b3_msb", 16384);
    for (int k = 0; k < 4; k++) begin
      rb[k] = 7'h7f;
      rt[k] = 9'h1ff;
    end
    single("all_ones", 32'h15257);

    // Back-to-back stream of 8 row sets.
    n_drained = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_rows();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("stream_drained", n_drained, 32'd8);

    // Stall for 5 cycles with a stream pending, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_rows();
      in_valid = 1'b1;
      step();
    end
    check("stall_accepts", q.size(), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_rows();
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stall_flushed", q.size(), 32'd0);

    // Fill both stages, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_rows();
    step();
    step();
    check("full_valid", 32'(out_valid), 32'd1);
    #3;
    do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_empty", 32'(out_valid), 32'd0);
    clear_rows(); rt[1] = 9'h003;
    single("post_rst", 12);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      rand_rows();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("final_flushed", q.size(), 32'd0);
    check("cnt2_saturated", 32'(txn_count2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
